// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The main entry drives decode; the skid entry absorbs one extra fetch while decode stalls.
module ifid_skid_reg #(
   parameter int               PC_W          = 32,
   parameter int               INSTR_W       = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = {INSTR_W{1'b0}},
   parameter bit               FLUSH_KEEP_PC = 1'b1,
   parameter int               CNT_W         = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               IFID_flush,
   input  logic               In_valid,
   output logic               In_ready,
   input  logic [PC_W-1:0]    PCAdder_in,
   input  logic [INSTR_W-1:0] Instruction_in,
   output logic               Out_valid,
   input  logic               Out_ready,
   output logic [PC_W-1:0]    PCAdder_out,
   output logic [INSTR_W-1:0] Instruction_out,
   output logic [1:0]         Occupancy,
   output logic [CNT_W-1:0]   Flush_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [PC_W-1:0]      mainPc_q, mainPc_d;
   logic [INSTR_W-1:0]   mainInstr_q, mainInstr_d;
   logic [PC_W-1:0]      skidPc_q, skidPc_d;
   logic [INSTR_W-1:0]   skidInstr_q, skidInstr_d;
   logic [CNT_W-1:0]     flushCnt_q, flushCnt_d;
   logic                 inFire, outFire;

   // Ready comes straight from the state register, so there is no path from Out_ready.
   assign In_ready        = (state_q != TWO);
   assign Out_valid       = (state_q != EMPTY);
   assign inFire          = In_valid & In_ready;
   assign outFire         = Out_valid & Out_ready;
   assign Occupancy       = state_q;
   assign PCAdder_out     = mainPc_q;
   assign Instruction_out = Out_valid ? mainInstr_q : NOP_INSTR;
   assign Flush_count     = flushCnt_q;

   always_comb begin
      state_d     = state_q;
      mainPc_d    = mainPc_q;
      mainInstr_d = mainInstr_q;
      skidPc_d    = skidPc_q;
      skidInstr_d = skidInstr_q;
      flushCnt_d  = flushCnt_q;
      if (IFID_flush) begin
         state_d     = EMPTY;
         mainPc_d    = FLUSH_KEEP_PC ? PCAdder_in : '0;
         mainInstr_d = NOP_INSTR;
         flushCnt_d  = (flushCnt_q == CNT_MAX) ? CNT_MAX : flushCnt_q + CNT_ONE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (inFire) begin
                  mainPc_d    = PCAdder_in;
                  mainInstr_d = Instruction_in;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  mainPc_d    = PCAdder_in;
                  mainInstr_d = Instruction_in;
               end else if (inFire) begin
                  skidPc_d    = PCAdder_in;
                  skidInstr_d = Instruction_in;
                  state_d     = TWO;
               end else if (outFire) begin
                  state_d     = EMPTY;
               end
            end
            TWO: begin
               if (outFire) begin
                  mainPc_d    = skidPc_q;
                  mainInstr_d = skidInstr_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= EMPTY;
         mainPc_q    <= '0;
         mainInstr_q <= NOP_INSTR;
         skidPc_q    <= '0;
         skidInstr_q <= NOP_INSTR;
         flushCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mainPc_q    <= mainPc_d;
         mainInstr_q <= mainInstr_d;
         skidPc_q    <= skidPc_d;
         skidInstr_q <= skidInstr_d;
         flushCnt_q  <= flushCnt_d;
      end
   end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: two instances (flush-keeps-PC with a 2-bit counter, flush-clears-PC
// with an 8-bit counter) share stimulus and are compared each cycle against a queue model.
module tb_ifid_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        Clk = 1'b0;
   logic        Rst, IFID_flush, In_valid, Out_ready;
   logic [31:0] PCAdder_in, Instruction_in;

   logic        aInReady, aOutValid, bInReady, bOutValid;
   logic [31:0] aPc, aInstr, bPc, bInstr;
   logic [1:0]  aOcc, bOcc;
   logic [1:0]  aCnt;
   logic [7:0]  bCnt;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      modelQ[$];
   logic [31:0] lastPcA, lastPcB;
   int          cntA, cntB;
   int          checkCount = 0;
   int          errorCount = 0;

   ifid_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .FLUSH_KEEP_PC(1'b1), .CNT_W(2)) dutA (
      .Clk(Clk), .Rst(Rst), .IFID_flush(IFID_flush), .In_valid(In_valid), .In_ready(aInReady),
      .PCAdder_in(PCAdder_in), .Instruction_in(Instruction_in), .Out_valid(aOutValid),
      .Out_ready(Out_ready), .PCAdder_out(aPc), .Instruction_out(aInstr),
      .Occupancy(aOcc), .Flush_count(aCnt)
   );

   ifid_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .FLUSH_KEEP_PC(1'b0), .CNT_W(8)) dutB (
      .Clk(Clk), .Rst(Rst), .IFID_flush(IFID_flush), .In_valid(In_valid), .In_ready(bInReady),
      .PCAdder_in(PCAdder_in), .Instruction_in(Instruction_in), .Out_valid(bOutValid),
      .Out_ready(Out_ready), .PCAdder_out(bPc), .Instruction_out(bInstr),
      .Occupancy(bOcc), .Flush_count(bCnt)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour: a FIFO of at most two entries; the output PC sticks to the last
   // entry that left, or to the flush/reset value, whenever the FIFO is empty.
   task automatic modelUpdate();
      bit     inFire, outFire;
      entry_t e;
      if (Rst) begin
         modelQ.delete();
         lastPcA = 0; lastPcB = 0; cntA = 0; cntB = 0;
      end else if (IFID_flush) begin
         modelQ.delete();
         lastPcA = PCAdder_in;
         lastPcB = 0;
         if (cntA < 3) cntA++;
         if (cntB < 255) cntB++;
      end else begin
         inFire  = In_valid && (modelQ.size() < 2);
         outFire = Out_ready && (modelQ.size() > 0);
         if (outFire) begin
            e = modelQ.pop_front();
            lastPcA = e.pc;
            lastPcB = e.pc;
         end
         if (inFire) begin
            e.pc    = PCAdder_in;
            e.instr = Instruction_in;
            modelQ.push_back(e);
         end
      end
   endtask

   task automatic checkAll();
      int          n;
      logic [31:0] expInstr, expPcA, expPcB;
      n        = modelQ.size();
      expInstr = (n > 0) ? modelQ[0].instr : NOP;
      expPcA   = (n > 0) ? modelQ[0].pc : lastPcA;
      expPcB   = (n > 0) ? modelQ[0].pc : lastPcB;
      checkOutput("a_occ",   64'(aOcc),      64'(n));
      checkOutput("a_valid", 64'(aOutValid), 64'(n > 0));
      checkOutput("a_ready", 64'(aInReady),  64'(n < 2));
      checkOutput("a_instr", 64'(aInstr),    64'(expInstr));
      checkOutput("a_pc",    64'(aPc),       64'(expPcA));
      checkOutput("a_cnt",   64'(aCnt),      64'(cntA));
      checkOutput("b_occ",   64'(bOcc),      64'(n));
      checkOutput("b_valid", 64'(bOutValid), 64'(n > 0));
      checkOutput("b_ready", 64'(bInReady),  64'(n < 2));
      checkOutput("b_instr", 64'(bInstr),    64'(expInstr));
      checkOutput("b_pc",    64'(bPc),       64'(expPcB));
      checkOutput("b_cnt",   64'(bCnt),      64'(cntB));
   endtask

   task automatic applyStimulus(input logic rst, input logic flush, input logic iv,
                                input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
      Rst            = rst;
      IFID_flush     = flush;
      In_valid       = iv;
      PCAdder_in     = pc;
      Instruction_in = instr;
      Out_ready      = ordy;
      @(posedge Clk);
      modelUpdate();
      #1;
      checkAll();
   endtask

   initial begin
      Rst = 1'b1; IFID_flush = 1'b0; In_valid = 1'b1; Out_ready = 1'b0;
      PCAdder_in = 32'h4; Instruction_in = 32'hA;
      lastPcA = 0; lastPcB = 0; cntA = 0; cntB = 0;
      #2;

      // Reset with In_valid high for two cycles.
      applyStimulus(1, 0, 1, 32'h4, 32'hA, 0);
      applyStimulus(1, 0, 1, 32'h4, 32'hA, 0);
      checkOutput("rst_occ",   64'(aOcc), 64'd0);
      checkOutput("rst_ready", 64'(aInReady), 64'd1);
      checkOutput("rst_instr", 64'(aInstr), 64'(NOP));

      // Streaming at full throughput.
      applyStimulus(0, 0, 1, 32'd4,  32'hA, 1);
      checkOutput("stream_a", 64'(aInstr), 64'hA);
      applyStimulus(0, 0, 1, 32'd8,  32'hB, 1);
      checkOutput("stream_b", 64'(aInstr), 64'hB);
      applyStimulus(0, 0, 1, 32'd12, 32'hC, 1);
      checkOutput("stream_c_pc", 64'(aPc), 64'd12);
      applyStimulus(0, 0, 0, 32'd0,  32'h0, 1);

      // Stall: third entry must be refused, then drained in order after re-offer.
      applyStimulus(0, 0, 1, 32'd4,  32'hA, 0);
      applyStimulus(0, 0, 1, 32'd8,  32'hB, 0);
      applyStimulus(0, 0, 1, 32'd12, 32'hC, 0);
      checkOutput("stall_ready", 64'(aInReady), 64'd0);
      checkOutput("stall_head",  64'(aInstr),   64'hA);
      applyStimulus(0, 0, 1, 32'd12, 32'hC, 1);
      checkOutput("drain_b", 64'(aInstr), 64'hB);
      applyStimulus(0, 0, 1, 32'd12, 32'hC, 1);
      checkOutput("drain_c", 64'(aInstr), 64'hC);
      applyStimulus(0, 0, 0, 32'd0,  32'h0, 1);

      // Flush while full with a simultaneous offer.
      applyStimulus(1, 0, 0, 32'd0, 32'h0, 0);
      applyStimulus(0, 0, 1, 32'd4, 32'hA, 0);
      applyStimulus(0, 0, 1, 32'd8, 32'hB, 0);
      applyStimulus(0, 1, 1, 32'h40, 32'hD, 0);
      checkOutput("flush_pc_keep",  64'(aPc), 64'h40);
      checkOutput("flush_pc_clear", 64'(bPc), 64'h0);
      checkOutput("flush_cnt",      64'(aCnt), 64'd1);

      // Reset wins over flush.
      applyStimulus(0, 0, 1, 32'd4, 32'hA, 0);
      applyStimulus(1, 1, 1, 32'h44, 32'hE, 1);
      checkOutput("prio_cnt", 64'(bCnt), 64'd0);
      checkOutput("prio_pc",  64'(aPc),  64'd0);

      // Saturation of the 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 1, 32'h100 + 32'(i), 32'h77, 0);
         checkOutput("sat_cnt", 64'(aCnt), 64'((i < 3) ? i + 1 : 3));
      end

      // Randomised traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 100) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                       $urandom, $urandom, ($urandom % 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ifid_skid_reg.md
# ifid_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the fetch stage (PC adder, instruction memory) and the decode stage. It replaces the single-entry IF/ID register with one that can stall without losing a fetched instruction, supports flush with bubble insertion, and counts flushes.

## Interface
- PC_W, 32, width of the PC+4 value
- INSTR_W, 32, instruction width
- NOP_INSTR, {INSTR_W{1'b0}}, instruction presented on a bubble, flush or reset
- FLUSH_KEEP_PC, 1, on flush: 1 = PCAdder_out takes PCAdder_in; 0 = PCAdder_out cleared to 0
- CNT_W, 8, width of the saturating flush counter

Ports:
- Clk  in  1  clock, all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- IFID_flush  in  1  discard all held entries and insert a bubble
- In_valid  in  1  fetch presents a valid PC/instruction pair
- In_ready  out  1  buffer accepts input this cycle
- PCAdder_in  in  PC_W  PC+4 from fetch
- Instruction_in  in  INSTR_W  fetched instruction
- Out_valid  out  1  decode-side entry valid
- Out_ready  in  1  decode consumes the entry this cycle
- PCAdder_out  out  PC_W  PC+4 to decode
- Instruction_out  out  INSTR_W  instruction to decode
- Occupancy  out  2  entries held (0, 1 or 2)
- Flush_count  out  CNT_W  number of flushes since reset, saturating

## Operation
- Transfer events: in_fire = In_valid & In_ready; out_fire = Out_valid & Out_ready.
- Storage: a main register drives the outputs; a skid register holds the overflow entry.
- States (encoded as Occupancy):
  - EMPTY (0): In_ready = 1, Out_valid = 0.
    - in_fire -> load main, go to ONE.
  - ONE (1): In_ready = 1, Out_valid = 1.
    - in_fire & out_fire -> load main, stay in ONE.
    - in_fire & !out_fire -> load skid, go to TWO.
    - !in_fire & out_fire -> go to EMPTY.
  - TWO (2): In_ready = 0, Out_valid = 1.
    - out_fire -> main <= skid, go to ONE.
    - In_valid is ignored in TWO.
- When Out_valid = 0, Instruction_out = NOP_INSTR. PCAdder_out holds its last value.
- In_ready depends only on state (registered). It has no combinational path from Out_ready.
- Flush (IFID_flush = 1, Rst = 0):
  - Next state is EMPTY and both entries are invalidated.
  - A simultaneous In_valid is discarded, and in_fire is not counted as accepted.
  - Instruction_out <= NOP_INSTR.
  - PCAdder_out <= PCAdder_in if FLUSH_KEEP_PC = 1, else 0.
  - Flush_count increments by 1 and saturates at 2^CNT_W-1.
- Priority: Rst > IFID_flush > handshake transfers.
- Entries leave in strict arrival order; no entry is duplicated or dropped, except on flush or reset.

## Timing
- Reset values (the cycle after Rst sampled high):
  - Occupancy = 0, Out_valid = 0, In_ready = 1.
  - PCAdder_out = 0, Instruction_out = NOP_INSTR, Flush_count = 0.
- Reset asserted mid-operation discards all entries, regardless of flush or handshakes in the same cycle.
- Latency: 1 cycle. An entry accepted at posedge N is on the outputs with Out_valid = 1 after posedge N.
- Throughput: 1 entry/cycle while Out_ready = 1.
- Stall: Out_ready low for k cycles accepts at most one extra entry (into skid). In_ready drops the cycle after skid fills and rises the cycle after the first out_fire in TWO.
- Flush takes effect at the same posedge it is sampled. Out_valid = 0 from the next cycle. In_ready = 1 from the next cycle.
- Flush_count at max value plus a flush stays at max value (no wrap).

## Test plan
- Reset: assert Rst 2 cycles with In_valid = 1 -> Occupancy = 0, Out_valid = 0, In_ready = 1, PCAdder_out = 0, Instruction_out = NOP_INSTR, Flush_count = 0.
- Streaming: Out_ready = 1; push PC 4, 8, 12 with instructions 0xA, 0xB, 0xC on consecutive cycles -> same pairs appear one cycle later, back-to-back, Occupancy = 1 throughout.
- Stall/skid: hold Out_ready = 0 and push 0xA, 0xB, 0xC -> 0xA on output, 0xB in skid, In_ready = 0, 0xC not accepted. Release Out_ready -> outputs 0xA, 0xB, then 0xC after re-offer, in order with no loss.
- Flush while full (Occupancy = 2), In_valid = 1, PCAdder_in = 0x40, FLUSH_KEEP_PC = 1 -> next cycle Occupancy = 0, Out_valid = 0, Instruction_out = NOP_INSTR, PCAdder_out = 0x40, Flush_count = 1, In_ready = 1.
- Priority: Rst and IFID_flush high together -> reset values, Flush_count = 0, PCAdder_out = 0.
- Saturation: CNT_W = 2, apply 5 flushes -> Flush_count sequence 1, 2, 3, 3, 3.
